rr_demux_sched: RTL and testbench

- Round-robin scheduler plus registered 1:4 stream demux.
- Accepts one valid/ready input stream and distributes it in fixed-length bursts across four output channels. Each output channel has its own valid/ready handshake.
- The arbiter serves only channels enabled in a runtime mask. It holds a grant for a whole burst, then moves to the next enabled channel.
- Sits between a single producer and four consumer lanes, and replaces a bare select-driven demux.

---
 rtl/rr_demux_sched.sv | 132 +++++++++++++
 tb/tb_rr_demux_sched.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_demux_sched.sv
// rtl/rr_demux_sched.sv - round-robin burst scheduler with registered 1:4 stream demux
// Distributes one valid/ready input stream over four output lanes in
// BURST_LEN-beat bursts, rotating among the lanes enabled in en_mask.
// Optional per-lane delivered-beat counters are built when RR_DEMUX_STATS_EN
// is defined; otherwise beat_cnt is tied to zero.
// Ports:
//   clk, rst                      rising-edge clock, async active-high reset
//   en_mask[3:0]                  lane eligibility, sampled only at arbitration
//   in_valid, in_data, in_ready   input stream handshake
//   out_valid[3:0]                one-hot lane valid for the shared out_data
//   out_data[WIDTH-1:0]           registered output beat
//   out_ready[3:0]                per-lane ready
//   cur_sel[1:0]                  lane currently holding the grant
//   busy                          high while a burst is being transferred
//   beat_cnt[63:0]                4 x 16-bit saturating delivered-beat counters
module rr_demux_sched #(
  parameter int WIDTH     = 8,
  parameter int BURST_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       en_mask,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [3:0]       out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic [3:0]       out_ready,
  output logic [1:0]       cur_sel,
  output logic             busy,
  output logic [63:0]      beat_cnt
);

  localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t          state, state_nxt;
  logic [1:0]      last_grant;
  logic [1:0]      out_ch;
  logic [1:0]      pick;
  logic [1:0]      cand;
  logic            pick_ok;
  logic [CW-1:0]   count;
  logic            accept;
  logic            last_beat;

  // Search last_grant+1 .. last_grant+4; iterating downwards lets the
  // nearest eligible lane overwrite any farther one.
  always_comb begin
    pick    = 2'd0;
    pick_ok = 1'b0;
    cand    = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      cand = last_grant + 2'(k);
      if (en_mask[cand]) begin
        pick    = cand;
        pick_ok = 1'b1;
      end
    end
  end

  // The held beat must leave (or be leaving this cycle) before a new one is
  // accepted, even if it belongs to a lane that no longer holds the grant.
  assign in_ready  = busy && ((out_valid == 4'd0) || out_ready[out_ch]);
  assign accept    = in_valid && in_ready;
  assign last_beat = (count == LAST_BEAT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_ok) state_nxt = XFER;
      XFER:    if (accept && last_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == XFER);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 2'd3;
      cur_sel    <= 2'd0;
      count      <= '0;
    end else if (state == IDLE) begin
      if (pick_ok) begin
        last_grant <= pick;
        cur_sel    <= pick;
        count      <= '0;
      end
    end else if (accept) begin
      count <= last_beat ? '0 : count + 1'b1;
    end
  end

  // Output register: refill on accept, otherwise clear once the lane takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 4'd0;
      out_data  <= '0;
      out_ch    <= 2'd0;
    end else if (accept) begin
      out_valid <= 4'b0001 << cur_sel;
      out_data  <= in_data;
      out_ch    <= cur_sel;
    end else if (out_ready[out_ch]) begin
      out_valid <= 4'd0;
    end
  end

`ifdef RR_DEMUX_STATS_EN
  for (genvar i = 0; i < 4; i++) begin : g_stats
    logic [15:0] cnt;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt <= 16'd0;
      else if (out_valid[i] && out_ready[i] && (cnt != 16'hFFFF)) cnt <= cnt + 16'd1;
    end
    assign beat_cnt[16*i +: 16] = cnt;
  end
`else
  assign beat_cnt = 64'd0;
`endif

endmodule

// File: tb/tb_rr_demux_sched.sv
// tb/tb_rr_demux_sched.sv - randomized scoreboard bench for rr_demux_sched
module tb_rr_demux_sched;
  localparam int WIDTH = 8;
  localparam int BL    = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       en_mask = 4'd0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready;
  logic [3:0]       out_valid;
  logic [WIDTH-1:0] out_data;
  logic [3:0]       out_ready = 4'd0;
  logic [1:0]       cur_sel;
  logic             busy;
  logic [63:0]      beat_cnt;

  always #5 clk = ~clk;

  rr_demux_sched #(.WIDTH(WIDTH), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst), .en_mask(en_mask),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .cur_sel(cur_sel), .busy(busy), .beat_cnt(beat_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: bursts of BL beats, each burst's lane chosen by rotating
  // from the previous lane to the next enabled one; per-lane FIFOs of beats.
  logic [WIDTH-1:0] exp_q[4][$];
  int               gq[$];
  int               m_last = 3;
  int               m_cnt = 0;
  int               m_ch = 0;
  int               acc_total = 0;
  int               deliv[4];
  logic [15:0]      st[4];
  int               cyc_n = 0;
  int               first_acc = -1;
  int               last_acc = -1;

  logic             fired = 1'b0;
  logic             p_fired = 1'b0;
  logic [3:0]       p_ov = 4'd0;
  logic [WIDTH-1:0] p_od = '0;
  logic             p_hit = 1'b0;

  logic             rand_valid = 1'b0;
  logic             rand_ready = 1'b0;
  logic             seq_data = 1'b1;

  function automatic int rr_pick(input int last, input logic [3:0] m);
    for (int k = 1; k <= 4; k++)
      if (m[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  task automatic clear_model;
    for (int i = 0; i < 4; i++) begin
      exp_q[i].delete();
      deliv[i] = 0;
      st[i] = 16'd0;
    end
    gq.delete();
    m_last = 3;
    m_cnt = 0;
    m_ch = 0;
    acc_total = 0;
    first_acc = -1;
    last_acc = -1;
  endtask

  always @(posedge clk) cyc_n <= cyc_n + 1;

  always @(negedge clk) begin
    if (rst) begin
      fired = 1'b0;
      p_fired = 1'b0;
      p_ov = 4'd0;
      p_od = '0;
      p_hit = 1'b0;
    end else begin
      chk("onehot", 64'($onehot0(out_valid)), 64'd1);
      chk("ready_without_busy", 64'(in_ready && !busy), 64'd0);
      if (!p_fired) chk("data_stable", 64'(out_data), 64'(p_od));
      if (p_ov != 4'd0 && !p_hit) chk("hold_valid", 64'(out_valid), 64'(p_ov));
      for (int i = 0; i < 4; i++) begin
        if (out_valid[i] && out_ready[i]) begin
          deliv[i]++;
          if (st[i] != 16'hFFFF) st[i] = st[i] + 16'd1;
          if (exp_q[i].size() == 0) chk($sformatf("extra_beat_ch%0d", i), 64'(out_data), 64'hDEAD);
          else chk($sformatf("data_ch%0d", i), 64'(out_data), 64'(exp_q[i].pop_front()));
        end
      end
      fired = in_valid && in_ready;
      if (fired) begin
        if (m_cnt == 0) begin
          chk("grant_mask_set", 64'(en_mask != 4'd0), 64'd1);
          m_ch = rr_pick(m_last, en_mask);
          if (m_ch < 0) m_ch = 0;
          m_last = m_ch;
          gq.push_back(m_ch);
        end
        chk("grant", 64'(cur_sel), 64'(m_ch));
        exp_q[m_ch].push_back(in_data);
        m_cnt = (m_cnt + 1) % BL;
        acc_total++;
        if (first_acc < 0) first_acc = cyc_n;
        last_acc = cyc_n;
      end
      p_ov = out_valid;
      p_od = out_data;
      p_hit = |(out_valid & out_ready);
      p_fired = fired;
    end
  end

  task automatic cyc;
    @(posedge clk);
    #1;
    if (fired) in_data = seq_data ? in_data + 1'b1 : WIDTH'($urandom);
    if (rand_valid) in_valid = ($urandom_range(0, 99) < 70);
    if (rand_ready) out_ready = 4'($urandom);
  endtask

  task automatic wait_cnt(input int target, input int budget, input string tag);
    int n = 0;
    while (m_cnt != target && n < budget) begin cyc(); n++; end
    if (m_cnt != target) chk(tag, 64'(m_cnt), 64'(target));
  endtask

  task automatic wait_acc(input int total, input int budget, input string tag);
    int n = 0;
    while (acc_total < total && n < budget) begin cyc(); n++; end
    if (acc_total < total) chk(tag, 64'(acc_total), 64'(total));
  endtask

  // Mask changes are made only where the arbitration outcome is unambiguous:
  // drop to zero mid-burst, let the burst finish, then apply the new mask.
  task automatic set_mask(input logic [3:0] nm);
    if (en_mask != 4'd0) begin
      wait_cnt(1, 2000, "timeout_mask_midburst");
      en_mask = 4'd0;
    end
    wait_cnt(0, 2000, "timeout_mask_drain");
    repeat (3) cyc();
    en_mask = nm;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    clear_model();
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain;
    rand_valid = 1'b0;
    rand_ready = 1'b0;
    in_valid = 1'b0;
    out_ready = 4'hF;
    repeat (6) cyc();
    for (int i = 0; i < 4; i++) chk($sformatf("lost_ch%0d", i), 64'(exp_q[i].size()), 64'd0);
  endtask

  logic [WIDTH-1:0] held;
  int               n;

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_cur_sel", 64'(cur_sel), 64'd0);
    chk("rst_beat_cnt", beat_cnt, 64'd0);

    // Full rotation, 0x00..0x0F, all lanes ready
    cyc();
    en_mask = 4'hF;
    out_ready = 4'hF;
    in_data = '0;
    in_valid = 1'b1;
    wait_acc(16, 100, "timeout_rotation");
    in_valid = 1'b0;
    repeat (4) cyc();
    chk("rotation_span", 64'(last_acc - first_acc), 64'd18);
    for (int i = 0; i < 4; i++) chk($sformatf("rotation_deliv_ch%0d", i), 64'(deliv[i]), 64'd4);

    // Sparse mask 1010
    rand_valid = 1'b1;
    set_mask(4'b1010);
    gq.delete();
    wait_acc(acc_total + 4 * BL, 400, "timeout_sparse");
    chk("sparse_len", 64'(gq.size() >= 4), 64'd1);
    if (gq.size() >= 4) begin
      chk("sparse_g0", 64'(gq[0]), 64'd1);
      chk("sparse_g1", 64'(gq[1]), 64'd3);
      chk("sparse_g2", 64'(gq[2]), 64'd1);
      chk("sparse_g3", 64'(gq[3]), 64'd3);
    end
    wait_cnt(2, 400, "timeout_sparse_mid");
    en_mask = 4'd0;
    wait_cnt(0, 400, "timeout_sparse_end");
    rand_valid = 1'b0;
    in_valid = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("mask0_busy", 64'(busy), 64'd0);
      chk("mask0_in_ready", 64'(in_ready), 64'd0);
      cyc();
    end

    // Backpressure mid-burst
    en_mask = 4'hF;
    wait_cnt(2, 100, "timeout_bp_mid");
    out_ready = 4'h0;
    @(negedge clk);
    held = out_data;
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_data_held", 64'(out_data), 64'(held));
      cyc();
    end
    out_ready = 4'hF;
    wait_cnt(0, 100, "timeout_bp_end");
    drain();

    // Reset mid-burst with out_valid high
    en_mask = 4'hF;
    in_valid = 1'b1;
    n = 0;
    while (!(busy && out_valid != 4'd0) && n < 50) begin cyc(); n++; end
    chk("pre_reset_active", 64'(busy && out_valid != 4'd0), 64'd1);
    #1;
    rst = 1'b1;
    clear_model();
    #1;
    chk("async_out_valid", 64'(out_valid), 64'd0);
    chk("async_in_ready", 64'(in_ready), 64'd0);
    chk("async_busy", 64'(busy), 64'd0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b1;
    n = 0;
    while (!busy && n < 20) begin cyc(); n++; end
    chk("post_reset_sel", 64'(cur_sel), 64'd0);

    // Handover: last ch0 beat stalled while ch1 is granted
    n = 0;
    do begin cyc(); n++; end while (!(fired && m_cnt == 0 && m_ch == 0) && n < 60);
    chk("handover_reached", 64'(fired && m_cnt == 0 && m_ch == 0), 64'd1);
    out_ready = 4'b1110;
    repeat (6) begin
      @(negedge clk);
      chk("handover_block", 64'(in_ready), 64'd0);
      chk("handover_held", 64'(out_valid), 64'b0001);
      cyc();
    end
    chk("handover_sel", 64'(cur_sel), 64'd1);
    out_ready = 4'hF;
    wait_acc(acc_total + 2 * BL, 100, "timeout_handover");
    drain();

    // Random phases
    seq_data = 1'b0;
    rand_valid = 1'b1;
    rand_ready = 1'b1;
    for (int ph = 0; ph < 6; ph++) begin
      set_mask(4'($urandom_range(1, 15)));
      repeat (150) cyc();
    end
    drain();

`ifdef RR_DEMUX_STATS_EN
    for (int i = 0; i < 4; i++) chk($sformatf("stat_model_ch%0d", i), 64'(beat_cnt[16*i +: 16]), 64'(st[i]));
    do_reset();
    seq_data = 1'b1;
    en_mask = 4'b0100;
    in_valid = 1'b1;
    out_ready = 4'hF;
    wait_acc(8, 100, "timeout_stat_ch2");
    en_mask = 4'd0;
    repeat (3) cyc();
    en_mask = 4'b0001;
    wait_acc(8 + 66000, 90000, "timeout_stat_ch0");
    drain();
    chk("stat_ch2", 64'(beat_cnt[47:32]), 64'd8);
    chk("stat_ch0_sat", 64'(beat_cnt[15:0]), 64'hFFFF);
    for (int i = 0; i < 4; i++) chk($sformatf("stat_final_ch%0d", i), 64'(beat_cnt[16*i +: 16]), 64'(st[i]));
`else
    chk("beat_cnt_off", beat_cnt, 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
